// File: rtl/fpaddsub_align_stage.sv
// Align stage of a tiny FP add/sub: orders the operands by magnitude and
// shifts the smaller mantissa right one bit per cycle, keeping a sticky bit.
module fpaddsub_align_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       Sa,
  input  logic       Sb,
  input  logic [5:0] ShiftDet,
  input  logic [4:0] InputExc,
  input  logic [6:0] Aout,
  input  logic [6:0] Bout,
  input  logic       Opout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       MaxAB,
  output logic [2:0] CExp,
  output logic       Smax,
  output logic       Smin,
  output logic [4:0] Mmax,
  output logic [6:0] Mmin,
  output logic [4:0] ExcOut,
  output logic       OpOut
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       maxab_q, maxab_d;
  logic [2:0] cexp_q, cexp_d;
  logic       smax_q, smax_d;
  logic       smin_q, smin_d;
  logic [4:0] mmax_q, mmax_d;
  logic [6:0] mmin_q, mmin_d;
  logic [4:0] exc_q, exc_d;
  logic       op_q, op_d;

  logic       b_gt;
  logic [6:0] op_mx, op_mn;
  logic [2:0] shamt;
  logic       accept;

  assign b_gt  = Bout > Aout;
  assign op_mx = b_gt ? Bout : Aout;
  assign op_mn = b_gt ? Aout : Bout;
  assign shamt = b_gt ? ShiftDet[5:3] : ShiftDet[2:0];

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    maxab_d = maxab_q;
    cexp_d  = cexp_q;
    smax_d  = smax_q;
    smin_d  = smin_q;
    mmax_d  = mmax_q;
    mmin_d  = mmin_q;
    exc_d   = exc_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          maxab_d = b_gt;
          cexp_d  = op_mx[6:4];
          smax_d  = b_gt ? Sb : Sa;
          smin_d  = b_gt ? Sa : Sb;
          mmax_d  = {|op_mx[6:4], op_mx[3:0]};
          mmin_d  = {|op_mn[6:4], op_mn[3:0], 2'b00};
          exc_d   = InputExc;
          op_d    = Opout;
          cnt_d   = shamt;
          // exceptional operands bypass alignment entirely
          if (shamt == 3'd0 || InputExc[4]) state_d = DONE;
          else                              state_d = SHIFT;
        end
      end
      SHIFT: begin
        mmin_d = {1'b0, mmin_q[6:2], mmin_q[1] | mmin_q[0]};
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      maxab_q <= 1'b0;
      cexp_q  <= '0;
      smax_q  <= 1'b0;
      smin_q  <= 1'b0;
      mmax_q  <= '0;
      mmin_q  <= '0;
      exc_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      maxab_q <= maxab_d;
      cexp_q  <= cexp_d;
      smax_q  <= smax_d;
      smin_q  <= smin_d;
      mmax_q  <= mmax_d;
      mmin_q  <= mmin_d;
      exc_q   <= exc_d;
      op_q    <= op_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign MaxAB     = maxab_q;
  assign CExp      = cexp_q;
  assign Smax      = smax_q;
  assign Smin      = smin_q;
  assign Mmax      = mmax_q;
  assign Mmin      = mmin_q;
  assign ExcOut    = exc_q;
  assign OpOut     = op_q;

endmodule

// File: tb/tb_fpaddsub_align_stage.sv
// Directed bench for fpaddsub_align_stage: hand-computed alignment results,
// latency, backpressure and reset behaviour.
module tb_fpaddsub_align_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       Sa, Sb;
  logic [5:0] ShiftDet;
  logic [4:0] InputExc;
  logic [6:0] Aout, Bout;
  logic       Opout;
  logic       out_valid;
  logic       out_ready;
  logic       MaxAB;
  logic [2:0] CExp;
  logic       Smax, Smin;
  logic [4:0] Mmax;
  logic [6:0] Mmin;
  logic [4:0] ExcOut;
  logic       OpOut;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpaddsub_align_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Sa(Sa), .Sb(Sb), .ShiftDet(ShiftDet), .InputExc(InputExc),
    .Aout(Aout), .Bout(Bout), .Opout(Opout),
    .out_valid(out_valid), .out_ready(out_ready),
    .MaxAB(MaxAB), .CExp(CExp), .Smax(Smax), .Smin(Smin),
    .Mmax(Mmax), .Mmin(Mmin), .ExcOut(ExcOut), .OpOut(OpOut)
  );

  // Present one operand pair, accept it, scramble inputs, return latency.
  task automatic run_op(input logic [6:0] a, input logic [6:0] b,
                        input logic sa, input logic sb,
                        input logic [5:0] sd, input logic [4:0] exc,
                        input logic op, output int lat);
    @(negedge clk);
    Aout = a; Bout = b; Sa = sa; Sb = sb;
    ShiftDet = sd; InputExc = exc; Opout = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Aout = 7'h7F; Bout = 7'h00; Sa = ~sa; Sb = ~sb;
    ShiftDet = 6'h3F; InputExc = ~exc; Opout = ~op;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL pop: out_valid=%b in_ready=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 ||
        {MaxAB, CExp, Smax, Smin, Mmax, Mmin, ExcOut, OpOut} !== '0) begin
      fails++;
      $display("FAIL reset_hold: rdy=%b vld=%b Mmin=%h want all 0",
               in_ready, out_valid, Mmin);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b vld=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_normal();
    int lat;
    run_op(7'h35, 7'h12, 1'b0, 1'b1, 6'h32, 5'b00001, 1'b1, lat);
    tests++;
    if (lat !== 3 || MaxAB !== 1'b0 || CExp !== 3'd3 || Mmax !== 5'h15 ||
        Mmin !== 7'h12 || Smax !== 1'b0 || Smin !== 1'b1 ||
        ExcOut !== 5'b00001 || OpOut !== 1'b1) begin
      fails++;
      $display("FAIL normal: lat=%0d MaxAB=%b CExp=%0d Mmax=%h Mmin=%h Smax=%b Smin=%b Exc=%b Op=%b want 3 0 3 15 12 0 1 00001 1",
               lat, MaxAB, CExp, Mmax, Mmin, Smax, Smin, ExcOut, OpOut);
    end
    pop();
  endtask

  task automatic test_swapped();
    int lat;
    run_op(7'h12, 7'h35, 1'b0, 1'b1, 6'h16, 5'b00000, 1'b0, lat);
    tests++;
    if (lat !== 3 || MaxAB !== 1'b1 || CExp !== 3'd3 || Mmax !== 5'h15 ||
        Mmin !== 7'h12 || Smax !== 1'b1 || Smin !== 1'b0) begin
      fails++;
      $display("FAIL swapped: lat=%0d MaxAB=%b CExp=%0d Mmax=%h Mmin=%h Smax=%b Smin=%b want 3 1 3 15 12 1 0",
               lat, MaxAB, CExp, Mmax, Mmin, Smax, Smin);
    end
    pop();
  endtask

  task automatic test_sticky();
    int lat;
    run_op(7'h61, 7'h0F, 1'b1, 1'b0, 6'h26, 5'b00000, 1'b0, lat);
    tests++;
    if (lat !== 7 || MaxAB !== 1'b0 || CExp !== 3'd6 ||
        Mmax !== 5'h11 || Mmin !== 7'h01 || Smax !== 1'b1) begin
      fails++;
      $display("FAIL sticky: lat=%0d MaxAB=%b CExp=%0d Mmax=%h Mmin=%h Smax=%b want 7 0 6 11 01 1",
               lat, MaxAB, CExp, Mmax, Mmin, Smax);
    end
    pop();
  endtask

  task automatic test_equal_exp();
    int lat;
    run_op(7'h23, 7'h25, 1'b0, 1'b0, 6'h00, 5'b00000, 1'b0, lat);
    tests++;
    if (lat !== 1 || MaxAB !== 1'b1 || CExp !== 3'd2 ||
        Mmax !== 5'h15 || Mmin !== 7'h4C) begin
      fails++;
      $display("FAIL equal_exp: lat=%0d MaxAB=%b CExp=%0d Mmax=%h Mmin=%h want 1 1 2 15 4c",
               lat, MaxAB, CExp, Mmax, Mmin);
    end
    pop();
    // identical magnitudes keep A as the larger operand
    run_op(7'h44, 7'h44, 1'b1, 1'b0, 6'h00, 5'b00000, 1'b0, lat);
    tests++;
    if (lat !== 1 || MaxAB !== 1'b0 || Smax !== 1'b1 ||
        Mmax !== 5'h14 || Mmin !== 7'h50) begin
      fails++;
      $display("FAIL equal_mag: lat=%0d MaxAB=%b Smax=%b Mmax=%h Mmin=%h want 1 0 1 14 50",
               lat, MaxAB, Smax, Mmax, Mmin);
    end
    pop();
  endtask

  task automatic test_exception();
    int lat;
    run_op(7'h70, 7'h10, 1'b0, 1'b0, 6'h05, 5'b10010, 1'b1, lat);
    tests++;
    if (lat !== 1 || MaxAB !== 1'b0 || CExp !== 3'd7 ||
        Mmin !== 7'h40 || ExcOut !== 5'b10010 || OpOut !== 1'b1) begin
      fails++;
      $display("FAIL exception: lat=%0d MaxAB=%b CExp=%0d Mmin=%h Exc=%b Op=%b want 1 0 7 40 10010 1",
               lat, MaxAB, CExp, Mmin, ExcOut, OpOut);
    end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(7'h35, 7'h12, 1'b0, 1'b1, 6'h32, 5'b00000, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      Aout = 7'h01; Bout = 7'h7E; ShiftDet = 6'h00;
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Mmin !== 7'h12 ||
          Mmax !== 5'h15 || MaxAB !== 1'b0 || CExp !== 3'd3) begin
        fails++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b Mmin=%h Mmax=%h MaxAB=%b want 1 0 12 15 0",
                 i, out_valid, in_ready, Mmin, Mmax, MaxAB);
      end
    end
    in_valid = 1'b0;
    pop();
  endtask

  task automatic test_back_to_back();
    int lat;
    // in_valid held high through SHIFT and DONE must not start a second op
    @(negedge clk);
    Aout = 7'h35; Bout = 7'h12; Sa = 1'b0; Sb = 1'b0;
    ShiftDet = 6'h02; InputExc = 5'b0; Opout = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    Aout = 7'h0F; Bout = 7'h61; ShiftDet = 6'h00;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat !== 3 || Mmin !== 7'h12 || Mmax !== 5'h15 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back: lat=%0d Mmin=%h Mmax=%h rdy=%b want 3 12 15 0",
               lat, Mmin, Mmax, in_ready);
    end
    in_valid = 1'b0;
    pop();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    @(negedge clk);
    Aout = 7'h61; Bout = 7'h0F; Sa = 1'b1; Sb = 1'b1;
    ShiftDet = 6'h06; InputExc = 5'b00011; Opout = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 ||
        {MaxAB, CExp, Smax, Smin, Mmax, Mmin, ExcOut, OpOut} !== '0) begin
      fails++;
      $display("FAIL reset_mid_shift: rdy=%b vld=%b CExp=%0d Mmin=%h Exc=%b want all 0",
               in_ready, out_valid, CExp, Mmin, ExcOut);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_release: rdy=%b vld=%b want 1/0",
               in_ready, out_valid);
    end
    run_op(7'h23, 7'h25, 1'b0, 1'b0, 6'h00, 5'b00000, 1'b0, lat);
    tests++;
    if (lat !== 1 || Mmin !== 7'h4C) begin
      fails++;
      $display("FAIL after_reset_op: lat=%0d Mmin=%h want 1 4c", lat, Mmin);
    end
    // reset while held in DONE
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || Mmin !== 7'h00 || Mmax !== 5'h00) begin
      fails++;
      $display("FAIL reset_in_done: vld=%b Mmin=%h Mmax=%h want 0 00 00",
               out_valid, Mmin, Mmax);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Sa = 1'b0; Sb = 1'b0;
    ShiftDet = '0; InputExc = '0;
    Aout = '0; Bout = '0; Opout = 1'b0;
    test_reset();
    test_normal();
    test_swapped();
    test_sticky();
    test_equal_exp();
    test_exception();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpaddsub_align_stage.md
FPADDSUB_ALIGN_STAGE -- requirements
Module: fpaddsub_align_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream prealign fields valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a new operand pair.
REQ-006 SHALL have inputs Sa, Sb (1 each), ShiftDet (6, {DBA[2:0], DAB[2:0]}), InputExc (5), Aout (7), Bout (7), Opout (1), all from the prealign stage.
REQ-007 SHALL have port out_valid  output  1  aligned result valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-009 SHALL have output MaxAB  1: 1 when |B| > |A|.
REQ-010 SHALL have output CExp  3: exponent of the larger operand.
REQ-011 SHALL have outputs Smax and Smin (1 each): signs of the larger and smaller operands.
REQ-012 SHALL have output Mmax  5: {hidden, mant[3:0]} of the larger operand.
REQ-013 SHALL have output Mmin  7: {hidden, mant[3:0], guard, sticky} of the smaller operand, after alignment.
REQ-014 SHALL have outputs ExcOut (5) and OpOut (1): InputExc and Opout, captured at acceptance.

Function
REQ-015 SHALL take operand formats with field [6:4] as the exponent and [3:0] as the mantissa; hidden bit = OR of the exponent bits.
REQ-016 SHALL set MaxAB = (Bout > Aout), compared as 7-bit unsigned values; equal magnitudes SHALL give MaxAB=0.
REQ-017 SHALL set the shift count = ShiftDet[5:3] when MaxAB=1, else ShiftDet[2:0]; range 0..7.
REQ-018 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE with rst low; the block SHALL NOT accept back-to-back transfers.
REQ-020 IDLE: on in_valid&in_ready, the block SHALL capture all fields and load Mmin = {hidden, mant, 0, 0}.
REQ-021 IDLE acceptance: next state SHALL be DONE if the shift count is 0 or InputExc[4]=1, else SHIFT.
REQ-022 SHIFT, each cycle: Mmin SHALL update to {0, Mmin[6:2], Mmin[1]|Mmin[0]} and the count SHALL decrement.
REQ-023 SHIFT SHALL go to DONE on the cycle the count reaches 0.
REQ-024 Latency SHALL be out_valid high N+1 cycles after the accept edge (N = shift count), or 1 cycle on exception.
REQ-025 DONE: out_valid SHALL be 1 and all outputs SHALL hold stable until out_ready=1.
REQ-026 DONE: on out_valid&out_ready, the next state SHALL be IDLE and out_valid SHALL drop.
REQ-027 On exception (InputExc[4]=1), Mmin SHALL remain unshifted and ExcOut SHALL pass through unchanged.
REQ-028 in_valid asserted outside IDLE SHALL be ignored.
REQ-029 In IDLE/SHIFT, out_ready SHALL be ignored.
REQ-030 Input fields SHALL be ignored except at the acceptance edge.

Reset
REQ-031 rst asserted at any time, including mid-SHIFT or while held in DONE, SHALL immediately force IDLE.
REQ-032 While rst is high, in_ready and out_valid SHALL be 0 and all data outputs (MaxAB, CExp, Smax, Smin, Mmax, Mmin, ExcOut, OpOut) SHALL be 0.
REQ-033 An in-flight operation SHALL be discarded on reset, and in_ready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-034 Normal shift: A=0x35, B=0x12, ShiftDet=0x32 -> after 3 cycles MaxAB=0, CExp=3, Mmax=0x15, Mmin=0x12.
REQ-035 Swapped operands: A=0x12, B=0x35, ShiftDet=0x16 -> after 3 cycles MaxAB=1, Smax=Sb, Mmax=0x15, Mmin=0x12.
REQ-036 Sticky case: A=0x61, B=0x0F, ShiftDet=0x26 -> after 7 cycles Mmin=0x01 (sticky set), Mmax=0x11, CExp=6.
REQ-037 Equal exponents: A=0x23, B=0x25, ShiftDet=0x00 -> after 1 cycle MaxAB=1, Mmax=0x15, Mmin=0x4C.
REQ-038 Exception: A=0x70, InputExc=5'b10010 -> out_valid after 1 cycle, Mmin unshifted, ExcOut=5'b10010.
REQ-039 Backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; assert rst mid-SHIFT -> IDLE with all outputs 0.
